// File: rtl/data_bus_decoder.sv
// ---------------------------------------------------------------------------
// data_bus_decoder
//
// Routes the core's data-port requests to one of N_SLAVES peripherals by
// address. Responses (grant, read data, error) return to the core in issue
// order. Addresses that match no slave are answered by an internal error
// responder one cycle after the grant.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   m_req/m_we/m_be   core request, write enable, byte enables
//   m_addr/m_wdata    core address and write data
//   m_gnt             core request accepted this cycle
//   m_rvalid/m_rdata  response valid and read data back to the core
//   m_err             bus error qualifier for the response
//   s_req             one request line per slave
//   s_we/s_be/s_addr/s_wdata  broadcast copies of the core request fields
//   s_gnt/s_rvalid/s_err      per-slave grant, response valid and error
//   s_rdata           per-slave read data, slave i in bits [32i+31:32i]
// ---------------------------------------------------------------------------
module data_bus_decoder #(
  parameter int                       N_SLAVES        = 4,
  parameter logic [N_SLAVES*32-1:0]   ADDR_BASE       = {32'h3000_0000, 32'h2000_0000,
                                                         32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0]   ADDR_MASK       = {N_SLAVES{32'hF000_0000}},
  parameter int                       MAX_OUTSTANDING = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_req,
  input  logic                     m_we,
  input  logic [3:0]               m_be,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  output logic                     m_gnt,
  output logic                     m_rvalid,
  output logic [31:0]              m_rdata,
  output logic                     m_err,
  output logic [N_SLAVES-1:0]      s_req,
  output logic                     s_we,
  output logic [3:0]               s_be,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [N_SLAVES-1:0]      s_gnt,
  input  logic [N_SLAVES-1:0]      s_rvalid,
  input  logic [N_SLAVES*32-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]      s_err
);

  // Index N_SLAVES stands for the internal error responder.
  localparam int IDX_W = $clog2(N_SLAVES + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [IDX_W-1:0] ERR_IDX  = IDX_W'(N_SLAVES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] tail_idx;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             err_flag;
  logic             push;
  logic             pop;

  // Request fields go to every slave unregistered; only s_req is steered.
  assign s_we    = m_we;
  assign s_be    = m_be;
  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;

  // Address decode: scanning from the top down lets the lowest matching
  // index win when regions overlap.
  always_comb begin
    sel = ERR_IDX;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32]) begin
        sel = IDX_W'(i);
      end
    end
  end

  // The tail is the most recently pushed entry, the head the oldest one.
  assign tail_idx = (wr_ptr == '0) ? fifo_mem[PTR_LAST] : fifo_mem[wr_ptr - PTR_W'(1)];
  assign head_idx = fifo_mem[rd_ptr];

  // Issue gating: a new request may only target the same destination as
  // the transactions already in flight, so responses can never overtake
  // each other. The check uses the registered count, so a full FIFO stays
  // stalled even in a cycle where the head is being answered.
  always_comb begin
    s_req = '0;
    m_gnt = 1'b0;
    if (rst && (count < CNT_MAX) && ((count == '0) || (sel == tail_idx))) begin
      if (sel == ERR_IDX) begin
        m_gnt = m_req;
      end else begin
        for (int i = 0; i < N_SLAVES; i++) begin
          if (sel == IDX_W'(i)) begin
            s_req[i] = m_req;
            m_gnt    = s_gnt[i];
          end
        end
      end
    end
  end

  // Response mux: only the head slave may answer. Responses from any other
  // slave, or with nothing outstanding, never reach the core.
  always_comb begin
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_err    = 1'b0;
    if (rst && (count != '0)) begin
      if (head_idx == ERR_IDX) begin
        m_rvalid = err_flag;
        m_err    = err_flag;
      end else begin
        for (int i = 0; i < N_SLAVES; i++) begin
          if ((head_idx == IDX_W'(i)) && s_rvalid[i]) begin
            m_rvalid = 1'b1;
            m_rdata  = s_rdata[32*i +: 32];
            m_err    = s_err[i];
          end
        end
      end
    end
  end

  assign push = m_req && m_gnt;
  assign pop  = m_rvalid;

  // Outstanding bookkeeping. err_flag marks an error-responder accept in
  // the previous cycle; its response is due exactly then.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_flag <= 1'b0;
    end else begin
      err_flag <= push && (sel == ERR_IDX);
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Destination storage needs no reset; entries are only read while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sel;
    end
  end

endmodule

// File: tb/tb_data_bus_decoder.sv
// ---------------------------------------------------------------------------
// tb_data_bus_decoder
//
// Randomized bench for data_bus_decoder. Slaves are modelled as queues of
// pending responses with random grant readiness and latency; the expected
// core-side behaviour comes from an in-order queue of issued transactions.
// A second instance uses an overlapping address map to exercise the
// lowest-index-wins decode rule.
// ---------------------------------------------------------------------------
module tb_data_bus_decoder;

  localparam int NS   = 4;
  localparam int MAXO = 2;
  localparam int ERRI = NS;
  localparam int NCYC = 4500;

  localparam logic [NS*32-1:0] BASE1 = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] BASE2 = {32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK  = {NS{32'hF000_0000}};

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
    longint      due;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    longint      due;
    bit          stale;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            m_req;
  logic            m_we;
  logic [3:0]      m_be;
  logic [31:0]     m_addr;
  logic [31:0]     m_wdata;
  logic            m_gnt, m_rvalid, m_err;
  logic [31:0]     m_rdata;
  logic [NS-1:0]   s_req;
  logic            s_we;
  logic [3:0]      s_be;
  logic [31:0]     s_addr, s_wdata;
  logic [NS-1:0]   s_gnt, s_rvalid, s_err, s_ready;
  logic [NS*32-1:0] s_rdata;

  logic            m_gnt2, m_rvalid2, m_err2;
  logic [31:0]     m_rdata2;
  logic [NS-1:0]   s_req2;
  logic            s_we2;
  logic [3:0]      s_be2;
  logic [31:0]     s_addr2, s_wdata2;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  exp_t   exp_q[$];
  rsp_t   slv_q[NS][$];
  int     last_idx = ERRI;
  bit     pend = 0;
  int     cnt2 = 0;
  bit     err2_last = 0;
  int     req_pct, ready_pct, dmin, dmax;

  always #5 clk = ~clk;

  // Slaves grant only what is actually requested from them.
  assign s_gnt = s_ready & s_req;

  data_bus_decoder #(
    .N_SLAVES(NS), .ADDR_BASE(BASE1), .ADDR_MASK(MASK), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err)
  );

  // Overlapping map: 0x1xxx_xxxx hits slaves 1 and 3. Its slaves never
  // grant, so only error-responder traffic is accepted there.
  data_bus_decoder #(
    .N_SLAVES(NS), .ADDR_BASE(BASE2), .ADDR_MASK(MASK), .MAX_OUTSTANDING(MAXO)
  ) dut2 (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt2), .m_rvalid(m_rvalid2), .m_rdata(m_rdata2), .m_err(m_err2),
    .s_req(s_req2), .s_we(s_we2), .s_be(s_be2), .s_addr(s_addr2), .s_wdata(s_wdata2),
    .s_gnt('0), .s_rvalid('0), .s_rdata('0), .s_err('0)
  );

  // Lowest slave whose masked base matches, else the error responder.
  function automatic int decode(input logic [31:0] addr, input logic [NS*32-1:0] base,
                                input logic [NS*32-1:0] mask);
    for (int i = 0; i < NS; i++) begin
      if ((addr & mask[32*i +: 32]) == base[32*i +: 32]) return i;
    end
    return ERRI;
  endfunction

  function automatic bit stale_free();
    for (int i = 0; i < NS; i++) begin
      for (int j = 0; j < slv_q[i].size(); j++) begin
        if (slv_q[i][j].stale) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle's inputs shortly after the rising edge.
  task automatic applyStimulus();
    int region;
    rst = (cyc < 3) ? 1'b0 : ($urandom_range(0, 99) != 0);
    if (!pend && stale_free() && ($urandom_range(0, 99) < req_pct)) begin
      pend    = 1'b1;
      region  = $urandom_range(0, 5);
      m_addr  = $urandom;
      if (region < 4) m_addr[31:28] = 4'(region);
      else            m_addr[31:28] = 4'($urandom_range(4, 15));
      m_we    = 1'($urandom_range(0, 1));
      m_be    = 4'($urandom);
      m_wdata = $urandom;
    end else if (!pend) begin
      m_addr  = $urandom;
      m_we    = 1'($urandom_range(0, 1));
      m_be    = 4'($urandom);
      m_wdata = $urandom;
    end
    m_req = pend;
    for (int i = 0; i < NS; i++) begin
      s_ready[i]          = ($urandom_range(0, 99) < ready_pct);
      s_rdata[32*i +: 32] = $urandom;
      s_err[i]            = 1'($urandom_range(0, 1));
      s_rvalid[i]         = 1'b0;
      if (slv_q[i].size() > 0) begin
        if (slv_q[i][0].due <= cyc) begin
          s_rvalid[i]         = 1'b1;
          s_rdata[32*i +: 32] = slv_q[i][0].data;
          s_err[i]            = slv_q[i][0].err;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        s_rvalid[i] = 1'b1;
      end
    end
  endtask

  // Compare the settled outputs with the transaction-level model, then
  // advance the model to what the next rising edge will do.
  task automatic evaluateCycle();
    int          sel, sel2, h, d;
    bit          can, can2;
    logic [NS-1:0] e_sreq, e_sreq2;
    logic        e_gnt, e_rv, e_er, e_gnt2, e_rv2;
    logic [31:0] e_rd;
    exp_t        e;
    rsp_t        r;
    longint      due;

    sel    = decode(m_addr, BASE1, MASK);
    can    = rst && (exp_q.size() < MAXO) && ((exp_q.size() == 0) || (sel == last_idx));
    e_sreq = '0;
    e_gnt  = 1'b0;
    if (can) begin
      if (sel == ERRI) e_gnt = m_req;
      else begin
        e_sreq[sel] = m_req;
        e_gnt       = m_req & s_ready[sel];
      end
    end

    e_rv = 1'b0; e_rd = '0; e_er = 1'b0;
    if (rst && (exp_q.size() > 0)) begin
      h = exp_q[0].idx;
      if (h == ERRI) begin
        if (exp_q[0].due == cyc) begin e_rv = 1'b1; e_er = 1'b1; end
      end else if (slv_q[h].size() > 0) begin
        if (!slv_q[h][0].stale && (slv_q[h][0].due <= cyc)) begin
          e_rv = 1'b1; e_rd = exp_q[0].data; e_er = exp_q[0].err;
        end
      end
    end

    checkOutput("s_req",    32'(s_req),    32'(e_sreq));
    checkOutput("m_gnt",    32'(m_gnt),    32'(e_gnt));
    checkOutput("m_rvalid", 32'(m_rvalid), 32'(e_rv));
    checkOutput("m_rdata",  m_rdata,       e_rd);
    checkOutput("m_err",    32'(m_err),    32'(e_er));
    checkOutput("s_addr",   s_addr,        m_addr);
    checkOutput("s_wdata",  s_wdata,       m_wdata);
    checkOutput("s_we_be",  32'({s_we, s_be}), 32'({m_we, m_be}));

    sel2    = decode(m_addr, BASE2, MASK);
    can2    = rst && (cnt2 < MAXO) && ((cnt2 == 0) || (sel2 == ERRI));
    e_sreq2 = '0;
    if (can2 && (sel2 != ERRI)) e_sreq2[sel2] = m_req;
    e_gnt2  = can2 && (sel2 == ERRI) && m_req;
    e_rv2   = rst && (cnt2 > 0) && err2_last;
    checkOutput("ovl_s_req",    32'(s_req2),    32'(e_sreq2));
    checkOutput("ovl_m_gnt",    32'(m_gnt2),    32'(e_gnt2));
    checkOutput("ovl_m_rvalid", 32'(m_rvalid2), 32'(e_rv2));
    checkOutput("ovl_m_err",    32'(m_err2),    32'(e_rv2));
    checkOutput("ovl_m_rdata",  m_rdata2,       32'h0);
    checkOutput("ovl_s_addr",   s_addr2 ^ s_wdata2, m_addr ^ m_wdata);
    checkOutput("ovl_s_we_be",  32'({s_we2, s_be2}), 32'({m_we, m_be}));

    // Slaves drop a presented response after one cycle.
    for (int i = 0; i < NS; i++) begin
      if ((slv_q[i].size() > 0) && (slv_q[i][0].due <= cyc)) void'(slv_q[i].pop_front());
    end

    if (!rst) begin
      exp_q.delete();
      pend      = 1'b0;
      cnt2      = 0;
      err2_last = 1'b0;
      for (int i = 0; i < NS; i++) begin
        for (int j = 0; j < slv_q[i].size(); j++) begin
          r = slv_q[i][j]; r.stale = 1'b1; slv_q[i][j] = r;
        end
      end
    end else begin
      if (e_rv) void'(exp_q.pop_front());
      if (e_gnt) begin
        pend     = 1'b0;
        last_idx = sel;
        if (sel == ERRI) begin
          e.idx = ERRI; e.data = '0; e.err = 1'b1; e.due = cyc + 1;
        end else begin
          d   = $urandom_range(dmin, dmax);
          due = cyc + d;
          if ((slv_q[sel].size() > 0) && (slv_q[sel][$].due >= due)) due = slv_q[sel][$].due + 1;
          r.data = $urandom; r.err = ($urandom_range(0, 7) == 0); r.due = due; r.stale = 1'b0;
          slv_q[sel].push_back(r);
          e.idx = sel; e.data = r.data; e.err = r.err; e.due = due;
        end
        exp_q.push_back(e);
      end
      cnt2      = cnt2 + int'(e_gnt2) - int'(e_rv2);
      err2_last = e_gnt2;
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b0; m_req = 1'b0; m_we = 1'b0; m_be = '0; m_addr = '0; m_wdata = '0;
    s_ready = '0; s_rvalid = '0; s_rdata = '0; s_err = '0;
    for (int n = 0; n < NCYC; n++) begin
      if (n < 1500)      begin req_pct = 90; ready_pct = 100; dmin = 3; dmax = 3; end
      else if (n < 3000) begin req_pct = 70; ready_pct = 50;  dmin = 1; dmax = 4; end
      else               begin req_pct = 85; ready_pct = 80;  dmin = 1; dmax = 2; end
      @(posedge clk);
      #1;
      applyStimulus();
      @(negedge clk);
      evaluateCycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
